// File: rtl/rc4_ksa_engine.sv
// rc4_ksa_engine: RC4 key scheduling over an external single-port S-box RAM, with optional identity fill.
module rc4_ksa_engine #(
  parameter int ADDR_W    = 8,
  parameter int KEY_BYTES = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              skip_init,
  input  logic [8*KEY_BYTES-1:0]            secret_key,
  input  logic [$clog2(KEY_BYTES+1)-1:0]    key_len,
  output logic [ADDR_W-1:0]                 mem_addr,
  output logic [ADDR_W-1:0]                 mem_data,
  output logic                              mem_wren,
  input  logic [ADDR_W-1:0]                 mem_q,
  output logic                              busy,
  output logic                              done
);
  localparam int KL_W = $clog2(KEY_BYTES + 1);
  localparam int K_W  = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [3:0] IDLE  = 4'd0;
  localparam logic [3:0] INIT  = 4'd1;
  localparam logic [3:0] RD_I  = 4'd2;
  localparam logic [3:0] WT_I  = 4'd3;
  localparam logic [3:0] CAP_I = 4'd4;
  localparam logic [3:0] RD_J  = 4'd5;
  localparam logic [3:0] WT_J  = 4'd6;
  localparam logic [3:0] CAP_J = 4'd7;
  localparam logic [3:0] WR_I  = 4'd8;
  localparam logic [3:0] WR_J  = 4'd9;
  localparam logic [3:0] DONE  = 4'd10;

  logic [3:0]             state_q, state_d;
  logic [ADDR_W-1:0]      i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
  logic [K_W-1:0]         k_q, k_d, last_q, last_d;
  logic [8*KEY_BYTES-1:0] key_q, key_d;
  logic [KL_W-1:0]        klen_eff;
  logic [7:0]             kbyte;

  assign klen_eff = (key_len == '0 || int'(key_len) > KEY_BYTES) ? KL_W'(KEY_BYTES) : key_len;

  // key[0] sits in the most significant byte of the latched key
  always_comb begin
    kbyte = '0;
    for (int n = 0; n < KEY_BYTES; n++)
      if (k_q == K_W'(n)) kbyte = key_q[8*(KEY_BYTES-1-n) +: 8];
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    last_d  = last_q;
    key_d   = key_q;
    si_d    = si_q;
    sj_d    = sj_q;
    case (state_q)
      IDLE: if (start) begin
        key_d   = secret_key;
        last_d  = K_W'(klen_eff - KL_W'(1));
        i_d     = '0;
        j_d     = '0;
        k_d     = '0;
        state_d = skip_init ? RD_I : INIT;
      end
      INIT: begin
        i_d     = i_q + ADDR_W'(1);
        state_d = (i_q == '1) ? RD_I : INIT;
      end
      RD_I:  state_d = WT_I;
      WT_I:  state_d = CAP_I;
      CAP_I: begin
        si_d    = mem_q;
        j_d     = j_q + mem_q + kbyte[ADDR_W-1:0];
        state_d = RD_J;
      end
      RD_J:  state_d = WT_J;
      WT_J:  state_d = CAP_J;
      CAP_J: begin
        sj_d    = mem_q;
        state_d = WR_I;
      end
      WR_I:  state_d = WR_J;
      WR_J: begin
        i_d     = i_q + ADDR_W'(1);
        k_d     = (k_q == last_q) ? '0 : k_q + K_W'(1);
        state_d = (i_q == '1) ? DONE : RD_I;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      last_q  <= '0;
      key_q   <= '0;
      si_q    <= '0;
      sj_q    <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      last_q  <= last_d;
      key_q   <= key_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
    end
  end

  assign mem_wren = state_q == INIT || state_q == WR_I || state_q == WR_J;
  assign mem_addr = (state_q inside {RD_J, WT_J, CAP_J, WR_J}) ? j_q : i_q;
  assign mem_data = (state_q == INIT) ? i_q : (state_q == WR_I) ? sj_q : (state_q == WR_J) ? si_q : '0;
  assign busy     = state_q != IDLE;
  assign done     = state_q == DONE;
endmodule
